// File: rtl/bin2gray_ptr_pkg.sv
// Shared Gray-code helpers for the async FIFO pointer path.
// Functions work on a fixed wide vector; callers size-cast to their pointer width.
package bin2gray_ptr_pkg;

  localparam int unsigned GW = 32;

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR by doubling shifts: equivalent to the MSB-down ripple, no descending loop.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] r;
    r = g;
    for (int unsigned s = 1; s < GW; s = s << 1) begin
      r = r ^ (r >> s);
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2gray_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded bus crossing into the local clock domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bin2gray_ptr.sv
// Async FIFO pointer: binary address, exported Gray pointer and registered
// full (write side) or empty (read side) flag against the synchronized remote pointer.
module bin2gray_ptr
  import bin2gray_ptr_pkg::*;
#(
  parameter int DW    = 4,
  parameter bit IS_WR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [DW:0]   remote_gray,
  output logic [DW-1:0] addr,
  output logic [DW:0]   gray_ptr,
  output logic          flag
);

  localparam int PW = DW + 1;

  if (DW < 2) begin : g_dw_check
    $error("bin2gray_ptr: DW must be at least 2");
  end

  logic [DW:0] bin_ptr;
  logic [DW:0] bin_nxt;
  logic [DW:0] gray_nxt;
  logic [DW:0] sync_gray;
  logic [DW:0] full_cmp;
  logic        inc_ok;
  logic        flag_nxt;

  sync_2ff #(.W(PW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (remote_gray),
    .q   (sync_gray)
  );

  // Full when the pointers differ only in the two MSBs of the Gray code.
  assign full_cmp = {~sync_gray[DW:DW-1], sync_gray[DW-2:0]};

  always_comb begin
    inc_ok   = inc & ~flag;
    bin_nxt  = bin_ptr + PW'(inc_ok);
    gray_nxt = PW'(bin2gray(GW'(bin_nxt)));
    flag_nxt = IS_WR ? (gray_nxt == full_cmp) : (gray_nxt == sync_gray);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_ptr  <= '0;
      gray_ptr <= '0;
      flag     <= ~IS_WR;
    end else begin
      bin_ptr  <= bin_nxt;
      gray_ptr <= gray_nxt;
      flag     <= flag_nxt;
    end
  end

  assign addr = bin_ptr[DW-1:0];

endmodule

// File: doc/bin2gray_ptr.md
BIN2GRAY_PTR -- requirements
Module: bin2gray_ptr

Interface
REQ-001 SHALL have parameter DW, default 4, address width; pointer width is DW+1 (MSB = wrap bit).
REQ-002 SHALL have parameter IS_WR, default 1; 1 = write side (flag means full), 0 = read side (flag means empty).
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named as listed below.
REQ-004 clk  input  1  rising-edge clock of the local domain.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 inc  input  1  request to advance the pointer by one this cycle.
REQ-007 remote_gray  input  DW+1  Gray pointer from the opposite clock domain, asynchronous to clk.
REQ-008 addr  output  DW  registered binary address, bin_ptr[DW-1:0].
REQ-009 gray_ptr  output  DW+1  registered Gray pointer for export to the opposite domain.
REQ-010 flag  output  1  registered full (IS_WR=1) or empty (IS_WR=0).

Function
REQ-011 SHALL hold an internal DW+1 bit binary pointer bin_ptr.
REQ-012 SHALL define inc_ok = inc & ~flag; an inc while flag=1 SHALL be ignored, with no pointer change.
REQ-013 SHALL compute bin_nxt = bin_ptr + inc_ok modulo 2^(DW+1), so all-ones wraps to 0.
REQ-014 SHALL compute gray_nxt = bin_nxt ^ (bin_nxt >> 1).
REQ-015 SHALL register bin_ptr <= bin_nxt and gray_ptr <= gray_nxt each clk edge, giving one-cycle latency from inc to the outputs.
REQ-016 gray_ptr SHALL change in at most one bit per clock cycle, including at wrap-around.
REQ-017 SHALL pass remote_gray through a two-flop synchronizer to produce sync_gray; no other logic SHALL sit between remote_gray and the first flop.
REQ-018 IS_WR=1: flag SHALL be registered as (gray_nxt == {~sync_gray[DW:DW-1], sync_gray[DW-2:0]}).
REQ-019 IS_WR=0: flag SHALL be registered as (gray_nxt == sync_gray).
REQ-020 A write-side flag SHALL assert on the same edge that captures the increment filling the last entry.
REQ-021 A read-side flag SHALL assert on the same edge that captures the increment consuming the last entry.
REQ-022 Deassertion of flag SHALL occur exactly 3 clk edges after remote_gray changes: 2 sync stages plus the flag register.
REQ-023 If inc is high and the remote pointer update arrives at sync_gray in the same cycle, flag SHALL be evaluated against the new sync_gray and the resulting gray_nxt.
REQ-024 SHALL require DW >= 2.

Reset
REQ-025 On rst high, the block SHALL immediately set bin_ptr, addr, gray_ptr and both synchronizer stages to 0, independent of clk.
REQ-026 On rst high, flag SHALL reset to 0 when IS_WR=1 and to 1 when IS_WR=0.
REQ-027 inc SHALL be ignored while rst is high; operation resumes on the first clk edge after rst deasserts.
REQ-028 Reset mid-operation SHALL discard all pointer state, with no partial increment retained.

Structure
REQ-029 Binary-to-Gray conversion SHALL be a shared function/constant in the team's common include, alongside the existing Gray-to-binary conversion.
REQ-030 The two-flop synchronizer SHALL be a separate sub-module named sync_2ff, parameterised by width.
REQ-031 One write-side and one read-side instance of bin2gray_ptr, together with the existing Gray-to-binary converter, SHALL form the async FIFO pointer path.

Verification (DW=2, pointer width 3)
REQ-032 Write side, remote_gray=000, inc held for 4 cycles -> gray_ptr 001,011,010,110; full=1 on the 4th edge; a 5th inc leaves gray_ptr=110 and addr=00.
REQ-033 Full state, then remote_gray changes to 001 -> full=0 exactly 3 edges later; the next inc gives gray_ptr=111.
REQ-034 Wrap, with remote_gray tracking so flag never blocks, 8 incs -> gray_ptr 001,011,010,110,111,101,100,000; each step has Hamming distance 1; addr wraps 11->00.
REQ-035 Read side, after reset -> empty=1; remote_gray=001 -> empty=0 after 3 edges; one inc -> gray_ptr=001 and empty=1 on that edge; a further inc is ignored.
REQ-036 Write side at bin_ptr=011, rst pulsed between clk edges -> addr, gray_ptr and sync stages=0 and full=0 immediately; read side under the same pulse -> empty=1 immediately.
